// File: rtl/coef_reg_bank.sv
// coef_reg_bank: double-buffered coefficient bank.
// Software-side logic edits the shadow bank (parallel load, single-coefficient
// write or serial shift). The active bank R copies the shadow atomically on a
// sample-boundary strobe, so the datapath never sees a half-updated set.
module coef_reg_bank #(
  parameter int              W    = 16,
  parameter int              N    = 2,
  parameter int              AW   = 1,
  parameter logic [N*W-1:0]  INIT = 32'h12EDED80
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [N*W-1:0]   D,
  input  logic             wr,
  input  logic [AW-1:0]    addr,
  input  logic [W-1:0]     din,
  input  logic             sen,
  input  logic             sin,
  input  logic             commit,
  input  logic             smp,
  output logic [N*W-1:0]   R,
  output logic [N*W-1:0]   S,
  output logic             pending,
  output logic             dirty,
  output logic             upd,
  output logic             err
);

  logic [N*W-1:0] r_s;
  logic [N*W-1:0] r_r;
  logic           r_pend;
  logic           r_dirty;
  logic           r_upd;
  logic           r_err;

  logic [N*W-1:0] w_s_nxt;
  logic           w_addr_ok;
  logic           w_shd_we;
  logic           w_wr_bad;
  logic           w_xfer;

  // Address range check is done at 32 bits so non-power-of-two N works.
  assign w_addr_ok = (32'(addr) < 32'(N));

  // A masked source (lower priority than an active one) has no side effects.
  assign w_shd_we  = ld | (wr & w_addr_ok) | (~wr & sen);
  assign w_wr_bad  = ~ld & wr & ~w_addr_ok;

  // A commit arriving together with smp transfers immediately.
  assign w_xfer    = smp & (r_pend | commit);

  // Next shadow value: ld beats wr beats sen; at most one source acts.
  always_comb begin
    w_s_nxt = r_s;
    if (ld) begin
      w_s_nxt = D;
    end else if (wr) begin
      if (w_addr_ok) begin
        for (int k = 0; k < N; k++) begin
          if (addr == AW'(k)) w_s_nxt[(N-k)*W-1 -: W] = din;
        end
      end
    end else if (sen) begin
      w_s_nxt = {r_s[N*W-2:0], sin};
    end
  end

  // Shadow and active banks; R samples the pre-edge shadow, so a write in
  // the transfer cycle is held back for the next commit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s <= INIT;
      r_r <= INIT;
    end else begin
      r_s <= w_s_nxt;
      if (w_xfer) r_r <= r_s;
    end
  end

  // Handshake and status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend  <= 1'b0;
      r_dirty <= 1'b0;
      r_upd   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_pend  <= w_xfer ? 1'b0 : (r_pend | commit);
      r_dirty <= w_shd_we | (r_dirty & ~w_xfer);
      r_upd   <= w_xfer;
      r_err   <= r_err | w_wr_bad;
    end
  end

  assign R       = r_r;
  assign S       = r_s;
  assign pending = r_pend;
  assign dirty   = r_dirty;
  assign upd     = r_upd;
  assign err     = r_err;

endmodule

// File: tb/tb_coef_reg_bank.sv
// Bench for coef_reg_bank: default instance driven through a scoreboard of
// expected R values (pushed on commit, popped on upd), plus instances with
// other W/N/AW settings for address-error and field-placement checks.
module tb_coef_reg_bank;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] sb[$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // ---------------- DUT0: W=16 N=2 AW=1 (defaults)
  logic        ld, wr, sen, sin, commit, smp;
  logic [31:0] D;
  logic [0:0]  addr;
  logic [15:0] din;
  logic [31:0] R, S;
  logic        pending, dirty, upd, err;

  coef_reg_bank dut0 (
    .clk(clk), .rst(rst), .ld(ld), .D(D), .wr(wr), .addr(addr), .din(din),
    .sen(sen), .sin(sin), .commit(commit), .smp(smp),
    .R(R), .S(S), .pending(pending), .dirty(dirty), .upd(upd), .err(err)
  );

  // ---------------- DUT1: W=16 N=3 AW=2
  logic        wr1;
  logic [1:0]  addr1;
  logic [15:0] din1;
  logic [47:0] R1, S1;
  logic        pend1, dirty1, upd1, err1;

  coef_reg_bank #(.W(16), .N(3), .AW(2), .INIT(48'h1111_2222_3333)) dut1 (
    .clk(clk), .rst(rst), .ld(1'b0), .D(48'h0), .wr(wr1), .addr(addr1), .din(din1),
    .sen(1'b0), .sin(1'b0), .commit(1'b0), .smp(1'b0),
    .R(R1), .S(S1), .pending(pend1), .dirty(dirty1), .upd(upd1), .err(err1)
  );

  // ---------------- DUT2: W=8 N=4 AW=2
  logic        wr2, commit2, smp2;
  logic [1:0]  addr2;
  logic [7:0]  din2;
  logic [31:0] R2, S2;
  logic        pend2, dirty2, upd2, err2;

  coef_reg_bank #(.W(8), .N(4), .AW(2), .INIT(32'h01020304)) dut2 (
    .clk(clk), .rst(rst), .ld(1'b0), .D(32'h0), .wr(wr2), .addr(addr2), .din(din2),
    .sen(1'b0), .sin(1'b0), .commit(commit2), .smp(smp2),
    .R(R2), .S(S2), .pending(pend2), .dirty(dirty2), .upd(upd2), .err(err2)
  );

  // ---------------- DUT3: W=24 N=1 AW=1
  logic        wr3, commit3, smp3;
  logic [0:0]  addr3;
  logic [23:0] din3;
  logic [23:0] R3, S3;
  logic        pend3, dirty3, upd3, err3;

  coef_reg_bank #(.W(24), .N(1), .AW(1), .INIT(24'hABCDEF)) dut3 (
    .clk(clk), .rst(rst), .ld(1'b0), .D(24'h0), .wr(wr3), .addr(addr3), .din(din3),
    .sen(1'b0), .sin(1'b0), .commit(commit3), .smp(smp3),
    .R(R3), .S(S3), .pending(pend3), .dirty(dirty3), .upd(upd3), .err(err3)
  );

  // Scoreboard side: every upd pulse must match the next queued R value.
  always @(negedge clk) begin
    if (upd) begin
      if (sb.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
      else                chk("sb_R", 64'(R), sb.pop_front());
    end
  end

  initial begin
    logic [31:0] ser;
    ld = 0; wr = 0; sen = 0; sin = 0; commit = 0; smp = 0; D = '0; addr = '0; din = '0;
    wr1 = 0; addr1 = '0; din1 = '0;
    wr2 = 0; commit2 = 0; smp2 = 0; addr2 = '0; din2 = '0;
    wr3 = 0; commit3 = 0; smp3 = 0; addr3 = '0; din3 = '0;

    // Reset state
    step(); step();
    chk("rst_R", 64'(R), 64'h12EDED80);
    chk("rst_S", 64'(S), 64'h12EDED80);
    chk("rst_flags", 64'({pending, dirty, upd, err}), 64'h0);
    rst = 1'b1;
    step();
    chk("rel_R", 64'(R), 64'h12EDED80);
    chk("rel_flags", 64'({pending, dirty, upd, err}), 64'h0);

    // Parallel load, commit held for 3 cycles without smp
    ld = 1; D = 32'hAAAA5555;
    step();
    ld = 0;
    chk("ld_S", 64'(S), 64'hAAAA5555);
    chk("ld_dirty", 64'(dirty), 64'd1);
    commit = 1; sb.push_back(64'hAAAA5555);
    step();
    commit = 0;
    chk("cm_pending", 64'(pending), 64'd1);
    step(); step();
    chk("cm_R_hold", 64'(R), 64'h12EDED80);
    smp = 1;
    step();
    smp = 0;
    chk("x_R", 64'(R), 64'hAAAA5555);
    chk("x_upd", 64'(upd), 64'd1);
    chk("x_pend_dirty", 64'({pending, dirty}), 64'h0);
    step();
    chk("x_upd_1cyc", 64'(upd), 64'd0);

    // smp alone does nothing
    smp = 1;
    step();
    smp = 0;
    chk("smp_only_upd", 64'(upd), 64'd0);
    chk("smp_only_R", 64'(R), 64'hAAAA5555);

    // Asynchronous reset while a commit is pending
    commit = 1;
    step();
    commit = 0;
    chk("pre_rst_pend", 64'(pending), 64'd1);
    rst = 1'b0;
    #1;
    chk("arst_pend", 64'(pending), 64'd0);
    chk("arst_R", 64'(R), 64'h12EDED80);
    chk("arst_S", 64'(S), 64'h12EDED80);
    rst = 1'b1;
    step();

    // Write then commit+smp next cycle
    wr = 1; addr = 1'b1; din = 16'h0042;
    step();
    wr = 0;
    commit = 1; smp = 1; sb.push_back(64'h12ED0042);
    step();
    chk("wc_R", 64'(R), 64'h12ED0042);
    // Write in the transfer cycle is not transferred
    wr = 1; addr = 1'b1; din = 16'h0099; sb.push_back(64'h12ED0042);
    step();
    wr = 0; commit = 0; smp = 0;
    chk("wx_R", 64'(R), 64'h12ED0042);
    chk("wx_S", 64'(S), 64'h12ED0099);
    chk("wx_dirty", 64'(dirty), 64'd1);

    // Serial shift, MSB first
    ser = 32'hDEADBEEF;
    sen = 1;
    for (int i = 31; i >= 0; i--) begin
      sin = ser[i];
      step();
    end
    sen = 0; sin = 0;
    chk("ser_S", 64'(S), 64'hDEADBEEF);
    commit = 1; smp = 1; sb.push_back(64'hDEADBEEF);
    step();
    commit = 0; smp = 0;
    chk("ser_R", 64'(R), 64'hDEADBEEF);
    // ld and sen together: only ld
    ld = 1; sen = 1; sin = 1; D = 32'h0F0F0F0F;
    step();
    ld = 0; sen = 0; sin = 0;
    chk("ld_sen_S", 64'(S), 64'h0F0F0F0F);
    // wr masked by ld: wr of illegal-free path not applied
    ld = 1; wr = 1; addr = 1'b0; din = 16'hFFFF; D = 32'h13572468;
    step();
    ld = 0; wr = 0;
    chk("ld_wr_S", 64'(S), 64'h13572468);

    // N=3 AW=2: illegal address
    wr1 = 1; addr1 = 2'd3; din1 = 16'hFFFF;
    step();
    wr1 = 0;
    chk("n3_err", 64'(err1), 64'd1);
    chk("n3_S", 64'(S1), 64'h111122223333);
    chk("n3_dirty", 64'(dirty1), 64'd0);
    wr1 = 1; addr1 = 2'd2; din1 = 16'h4444;
    step();
    chk("n3_S_wr2", 64'(S1), 64'h111122224444);
    addr1 = 2'd3; din1 = 16'h5555;
    step();
    wr1 = 0;
    step();
    chk("n3_err_sticky", 64'(err1), 64'd1);
    chk("n3_dirty_keep", 64'(dirty1), 64'd1);
    chk("n3_S_keep", 64'(S1), 64'h111122224444);

    // W=8 N=4: per-coefficient writes
    for (int k = 0; k < 4; k++) begin
      wr2 = 1; addr2 = 2'(k); din2 = 8'(8'hA0 + k);
      step();
    end
    wr2 = 0;
    chk("w8_R_hold", 64'(R2), 64'h01020304);
    commit2 = 1; smp2 = 1;
    step();
    commit2 = 0; smp2 = 0;
    chk("w8_R", 64'(R2), 64'hA0A1A2A3);
    wr2 = 1; addr2 = 2'd2; din2 = 8'h5C;
    step();
    wr2 = 0;
    commit2 = 1; smp2 = 1;
    step();
    commit2 = 0; smp2 = 0;
    chk("w8_R_f2", 64'(R2), 64'hA0A15CA3);

    // W=24 N=1
    wr3 = 1; addr3 = 1'b0; din3 = 24'h123456;
    step();
    wr3 = 0;
    commit3 = 1;
    step();
    commit3 = 0; smp3 = 1;
    step();
    smp3 = 0;
    chk("w24_R", 64'(R3), 64'h123456);
    chk("w24_err0", 64'(err3), 64'd0);
    wr3 = 1; addr3 = 1'b1; din3 = 24'hFFFFFF;
    step();
    wr3 = 0;
    chk("w24_err", 64'(err3), 64'd1);
    chk("w24_S", 64'(S3), 64'h123456);

    step(); step();
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
